// File: rtl/cfg_stream_writer.sv
// ============================================================================
// Module      : cfg_stream_writer
// Description : Turns a byte stream of configuration frames into bursts of
//               single-cycle tile writes with an auto-incrementing address.
//               Optional macro CFG_WRITER_CHECKSUM_EN adds a trailing XOR
//               checksum byte per frame.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cfg_stream_writer #(
  parameter int NB_TILES = 16,
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 8
) (
  input  logic                conf,
  input  logic                reset,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [NB_TILES-1:0] select_tile,
  output logic [ADDR_W-1:0]   address_tile,
  output logic [DATA_W-1:0]   data_tile,
  output logic                busy,
  output logic                frame_done,
  output logic                err,
  input  logic                err_clr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CNT,
    S_AHI,
    S_ALO,
    S_DATA
`ifdef CFG_WRITER_CHECKSUM_EN
    , S_CHK
`endif
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   tile_q, tile_d;
  logic                discard_q, discard_d;
  logic [8:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [NB_TILES-1:0] sel_q, sel_d;
  logic [ADDR_W-1:0]   addr_tile_q, addr_tile_d;
  logic [DATA_W-1:0]   data_tile_q, data_tile_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                err_set;
`ifdef CFG_WRITER_CHECKSUM_EN
  logic [DATA_W-1:0]   xor_q, xor_d;
`endif

  always_comb begin
    state_d     = state_q;
    tile_d      = tile_q;
    discard_d   = discard_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    sel_d       = '0;
    addr_tile_d = addr_tile_q;
    data_tile_d = data_tile_q;
    done_d      = 1'b0;
    err_set     = 1'b0;
`ifdef CFG_WRITER_CHECKSUM_EN
    xor_d       = xor_q;
`endif

    if (in_valid) begin
`ifdef CFG_WRITER_CHECKSUM_EN
      xor_d = (state_q == S_IDLE) ? in_data : (xor_q ^ in_data);
`endif
      case (state_q)
        S_IDLE: begin
          // Out-of-range tile: consume the frame but never strobe.
          tile_d    = in_data;
          discard_d = (32'(in_data) >= 32'(NB_TILES));
          err_set   = discard_d;
          state_d   = S_CNT;
        end
        S_CNT: begin
          cnt_d   = (in_data == '0) ? 9'd256 : 9'(in_data);
          state_d = S_AHI;
        end
        S_AHI: begin
          addr_d  = {in_data[ADDR_W-9:0], addr_q[7:0]};
          state_d = S_ALO;
        end
        S_ALO: begin
          addr_d  = {addr_q[ADDR_W-1:8], in_data[7:0]};
          state_d = S_DATA;
        end
        S_DATA: begin
          sel_d       = discard_q ? '0 : (NB_TILES'(1) << tile_q);
          addr_tile_d = addr_q;
          data_tile_d = in_data;
          addr_d      = addr_q + ADDR_W'(1);
          cnt_d       = cnt_q - 9'd1;
          if (cnt_q == 9'd1) begin
`ifdef CFG_WRITER_CHECKSUM_EN
            state_d = S_CHK;
`else
            state_d = S_IDLE;
            done_d  = 1'b1;
`endif
          end
        end
`ifdef CFG_WRITER_CHECKSUM_EN
        S_CHK: begin
          err_set = (in_data != xor_q);
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
`endif
        default: state_d = S_IDLE;
      endcase
    end

    // A new error in the same cycle as a clear request takes priority.
    err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
  end

  always_ff @(posedge conf) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      tile_q      <= '0;
      discard_q   <= 1'b0;
      cnt_q       <= '0;
      addr_q      <= '0;
      sel_q       <= '0;
      addr_tile_q <= '0;
      data_tile_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef CFG_WRITER_CHECKSUM_EN
      xor_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      tile_q      <= tile_d;
      discard_q   <= discard_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      sel_q       <= sel_d;
      addr_tile_q <= addr_tile_d;
      data_tile_q <= data_tile_d;
      done_q      <= done_d;
      err_q       <= err_d;
`ifdef CFG_WRITER_CHECKSUM_EN
      xor_q       <= xor_d;
`endif
    end
  end

  assign in_ready     = reset;
  assign select_tile  = sel_q;
  assign address_tile = addr_tile_q;
  assign data_tile    = data_tile_q;
  assign busy         = (state_q != S_IDLE);
  assign frame_done   = done_q;
  assign err          = err_q;

endmodule

`default_nettype wire

// File: tb/tb_cfg_stream_writer.sv
// ============================================================================
// Module      : tb_cfg_stream_writer
// Description : Directed scoreboard bench for cfg_stream_writer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cfg_stream_writer;

`ifdef CFG_WRITER_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic        conf = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] select_tile;
  logic [9:0]  address_tile;
  logic [7:0]  data_tile;
  logic        busy;
  logic        frame_done;
  logic        err;
  logic        err_clr = 1'b0;

  cfg_stream_writer #(.NB_TILES(16), .ADDR_W(10), .DATA_W(8)) dut (
    .conf(conf), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .select_tile(select_tile), .address_tile(address_tile),
    .data_tile(data_tile), .busy(busy), .frame_done(frame_done), .err(err),
    .err_clr(err_clr)
  );

  always #5 conf = ~conf;

  typedef struct {
    logic [15:0] sel;
    logic [9:0]  addr;
    logic [7:0]  data;
    logic        done;
    int          cyc;
  } wr_t;

  wr_t        exp_q[$];
  wr_t        obs_q[$];
  logic [7:0] frame_q[$];
  logic [7:0] dq[$];
  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  int         done_cnt = 0;
  wr_t        m_w;

  // Observe strobes away from the active edge.
  always @(negedge conf) begin
    cyc = cyc + 1;
    if (frame_done) done_cnt = done_cnt + 1;
    if (select_tile != '0) begin
      m_w.sel  = select_tile;
      m_w.addr = address_tile;
      m_w.data = data_tile;
      m_w.done = frame_done;
      m_w.cyc  = cyc;
      obs_q.push_back(m_w);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic build(input logic [7:0] tile, input logic [9:0] addr);
    logic [9:0] a;
    logic [7:0] x;
    wr_t        e;
    int         n;
    frame_q.delete();
    n = dq.size();
    frame_q.push_back(tile);
    frame_q.push_back(8'(n));
    frame_q.push_back({6'b0, addr[9:8]});
    frame_q.push_back(addr[7:0]);
    a = addr;
    for (int i = 0; i < n; i++) begin
      frame_q.push_back(dq[i]);
      if (tile < 8'd16) begin
        e.sel  = 16'(1) << tile;
        e.addr = a;
        e.data = dq[i];
        e.done = (i == n - 1) && !CHK_EN;
        e.cyc  = 0;
        exp_q.push_back(e);
      end
      a = a + 10'd1;
    end
    if (CHK_EN) begin
      x = '0;
      foreach (frame_q[i]) x = x ^ frame_q[i];
      frame_q.push_back(x);
    end
  endtask

  task automatic send(input int nmax, input bit gaps);
    int g;
    for (int i = 0; i < frame_q.size() && i < nmax; i++) begin
      in_data  = frame_q[i];
      in_valid = 1'b1;
      @(posedge conf); #1;
      if (gaps) begin
        in_valid = 1'b0;
        g = $urandom_range(1, 3);
        repeat (g) begin @(posedge conf); #1; end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic check_writes(input string tag, input bit consec);
    wr_t e, o;
    int  prev;
    repeat (3) @(negedge conf);
    chk({tag, " strobe count"}, obs_q.size(), exp_q.size());
    prev = -1;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      chk({tag, " sel"},  32'(o.sel),  32'(e.sel));
      chk({tag, " addr"}, 32'(o.addr), 32'(e.addr));
      chk({tag, " data"}, 32'(o.data), 32'(e.data));
      chk({tag, " done"}, 32'(o.done), 32'(e.done));
      if (consec && prev >= 0) chk({tag, " consecutive"}, o.cyc, prev + 1);
      prev = o.cyc;
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  int d0;

  initial begin
    // Reset state.
    repeat (3) @(posedge conf); #1;
    @(negedge conf);
    chk("rst in_ready", 32'(in_ready), 0);
    chk("rst select", 32'(select_tile), 0);
    chk("rst address", 32'(address_tile), 0);
    chk("rst data", 32'(data_tile), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst done", 32'(frame_done), 0);
    chk("rst err", 32'(err), 0);
    @(posedge conf); #1;
    reset = 1'b1;
    @(negedge conf);
    chk("in_ready after reset", 32'(in_ready), 1);

    // Basic frame.
    d0 = done_cnt;
    dq = '{8'hAA, 8'hBB, 8'hCC};
    build(8'h02, 10'h1FE);
    send(1000, 1'b0);
    check_writes("basic", 1'b1);
    chk("basic done pulses", done_cnt - d0, 1);
    chk("basic err", 32'(err), 0);
    chk("basic busy", 32'(busy), 0);

    // Address wrap.
    d0 = done_cnt;
    dq = '{8'h11, 8'h22};
    build(8'h00, 10'h3FF);
    send(1000, 1'b0);
    check_writes("wrap", 1'b1);
    chk("wrap err", 32'(err), 0);
    chk("wrap done pulses", done_cnt - d0, 1);

    // Bad tile index.
    d0 = done_cnt;
    dq = '{8'h55};
    build(8'h10, 10'h000);
    send(1000, 1'b0);
    check_writes("badtile", 1'b0);
    chk("badtile err", 32'(err), 1);
    chk("badtile busy", 32'(busy), 0);
    chk("badtile done pulses", done_cnt - d0, 1);
    repeat (2) @(negedge conf);
    chk("err sticky", 32'(err), 1);
    err_clr = 1'b1;
    @(posedge conf); #1;
    err_clr = 1'b0;
    @(negedge conf);
    chk("err_clr", 32'(err), 0);

    // in_valid gaps throughout the frame.
    d0 = done_cnt;
    dq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    build(8'h03, 10'h0F0);
    send(1000, 1'b1);
    check_writes("gaps", 1'b0);
    chk("gaps done pulses", done_cnt - d0, 1);

    // Reset after the address-low byte.
    dq = '{8'h01, 8'h02, 8'h03};
    build(8'h01, 10'h010);
    exp_q.delete();
    send(4, 1'b0);
    @(negedge conf);
    chk("pre-reset busy", 32'(busy), 1);
    reset = 1'b0;
    @(posedge conf); #1;
    @(negedge conf);
    chk("midrst busy", 32'(busy), 0);
    chk("midrst select", 32'(select_tile), 0);
    chk("midrst address", 32'(address_tile), 0);
    chk("midrst data", 32'(data_tile), 0);
    chk("midrst in_ready", 32'(in_ready), 0);
    reset = 1'b1;
    @(posedge conf); #1;
    obs_q.delete();
    dq = '{8'h77, 8'h88};
    build(8'h0F, 10'h2A0);
    send(1000, 1'b0);
    check_writes("after reset", 1'b1);

    // Count byte 0 means 256 data bytes.
    d0 = done_cnt;
    dq.delete();
    for (int i = 0; i < 256; i++) dq.push_back(8'(i * 7 + 3));
    build(8'h07, 10'h180);
    send(1000, 1'b0);
    check_writes("count256", 1'b1);
    chk("count256 done pulses", done_cnt - d0, 1);

`ifdef CFG_WRITER_CHECKSUM_EN
    // Good and bad checksum.
    dq = '{8'h3C};
    build(8'h01, 10'h005);
    send(1000, 1'b0);
    check_writes("chk good", 1'b0);
    chk("chk good err", 32'(err), 0);
    dq = '{8'h3C};
    build(8'h01, 10'h005);
    frame_q[frame_q.size() - 1] = 8'h00;
    send(1000, 1'b0);
    check_writes("chk bad", 1'b0);
    chk("chk bad err", 32'(err), 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
